// File: rtl/eth_rx_hdr_parse_if.sv
// Signal bundle for eth_rx_hdr_parse: MAC frame stream in, header and re-aligned payload out.
// slave is the parser's view, master is the surrounding environment's view.
interface eth_rx_hdr_parse_if #(
    parameter int DATA_W     = 512,
    parameter int PADBYTES_W = 6,
    parameter int MTU_SIZE_W = 16
);
    // Every channel transfers on a clock edge where valid and ready are both 1;
    // a sender holds valid and its payload stable until that edge, and ready may
    // depend combinationally on valid.
    logic                  src_eth_hdr_val;
    logic [DATA_W-1:0]     src_eth_hdr_data;
    logic [MTU_SIZE_W-1:0] src_eth_hdr_frame_size;
    logic                  src_eth_hdr_data_last;
    logic [PADBYTES_W-1:0] src_eth_hdr_data_padbytes;
    logic                  eth_hdr_src_rdy;

    logic                  eth_hdr_dst_hdr_val;
    logic [47:0]           eth_hdr_dst_dst_mac;
    logic [47:0]           eth_hdr_dst_src_mac;
    logic [15:0]           eth_hdr_dst_eth_type;
    logic [MTU_SIZE_W-1:0] eth_hdr_dst_payload_len;
    logic                  dst_eth_hdr_hdr_rdy;

    logic                  eth_hdr_dst_data_val;
    logic [DATA_W-1:0]     eth_hdr_dst_data;
    logic                  eth_hdr_dst_data_last;
    logic [PADBYTES_W-1:0] eth_hdr_dst_data_padbytes;
    logic                  dst_eth_hdr_data_rdy;

    logic [1:0]            dbg_state;

    modport slave (
        input  src_eth_hdr_val, src_eth_hdr_data, src_eth_hdr_frame_size,
               src_eth_hdr_data_last, src_eth_hdr_data_padbytes,
               dst_eth_hdr_hdr_rdy, dst_eth_hdr_data_rdy,
        output eth_hdr_src_rdy, eth_hdr_dst_hdr_val, eth_hdr_dst_dst_mac,
               eth_hdr_dst_src_mac, eth_hdr_dst_eth_type, eth_hdr_dst_payload_len,
               eth_hdr_dst_data_val, eth_hdr_dst_data, eth_hdr_dst_data_last,
               eth_hdr_dst_data_padbytes, dbg_state
    );

    modport master (
        output src_eth_hdr_val, src_eth_hdr_data, src_eth_hdr_frame_size,
               src_eth_hdr_data_last, src_eth_hdr_data_padbytes,
               dst_eth_hdr_hdr_rdy, dst_eth_hdr_data_rdy,
        input  eth_hdr_src_rdy, eth_hdr_dst_hdr_val, eth_hdr_dst_dst_mac,
               eth_hdr_dst_src_mac, eth_hdr_dst_eth_type, eth_hdr_dst_payload_len,
               eth_hdr_dst_data_val, eth_hdr_dst_data, eth_hdr_dst_data_last,
               eth_hdr_dst_data_padbytes, dbg_state
    );
endinterface

// File: rtl/eth_rx_hdr_parse.sv
// Strips the 14-byte Ethernet header and re-aligns the payload to byte lane 0.
// Define ETH_RX_HDR_ZERO_PAD_EN to zero the unused trailing lanes of the last payload beat.
module eth_rx_hdr_parse #(
    parameter int DATA_W     = 512,
    parameter int DATA_BYTES = DATA_W / 8,
    parameter int PADBYTES_W = 6,
    parameter int MTU_SIZE_W = 16
) (
    input logic               clk,
    input logic               rst,
    eth_rx_hdr_parse_if.slave bus
);
    localparam int HDR_BYTES = 14;
    localparam int HDR_W     = HDR_BYTES * 8;
    localparam int REM_W     = (DATA_BYTES - HDR_BYTES) * 8;

    typedef enum logic [1:0] {FIRST = 2'd0, MID = 2'd1, DRAIN = 2'd2} state_t;

    state_t                state;
    logic                  hdr_val;
    logic [47:0]           dst_mac;
    logic [47:0]           src_mac;
    logic [15:0]           eth_type;
    logic [MTU_SIZE_W-1:0] payload_len;
    logic [REM_W-1:0]      rem_reg;
    logic [PADBYTES_W-1:0] drain_pad;

    logic                  src_rdy;
    logic                  data_val;
    logic                  data_last;
    logic [PADBYTES_W-1:0] data_pad;
    logic [DATA_W-1:0]     data_raw;
    logic [DATA_W-1:0]     data_out;
    logic                  in_fire;
    logic                  hdr_fire;
    logic                  runt;
    logic                  fold_in;
    logic [PADBYTES_W-1:0] f_mod;
    logic [PADBYTES_W-1:0] frame_pad;
    logic                  padbytes_in_unused;

    // Frame length alone drives beat accounting; upstream padbytes are redundant.
    assign padbytes_in_unused = ^bus.src_eth_hdr_data_padbytes;

    assign f_mod     = bus.src_eth_hdr_frame_size[PADBYTES_W-1:0];
    // (14 - F) mod 64 equals (64 - P%64) mod 64, the trailing unused byte count.
    assign frame_pad = PADBYTES_W'(HDR_BYTES) - f_mod;
    assign runt      = bus.src_eth_hdr_frame_size <= MTU_SIZE_W'(HDR_BYTES);
    // Tail of 1..14 bytes fits in the free lanes behind rem_reg: no drain beat.
    assign fold_in   = (f_mod != '0) && (f_mod <= PADBYTES_W'(HDR_BYTES));
    assign in_fire   = bus.src_eth_hdr_val && src_rdy;
    assign hdr_fire  = hdr_val && bus.dst_eth_hdr_hdr_rdy;

    always_comb begin
        src_rdy   = 1'b0;
        data_val  = 1'b0;
        data_last = 1'b0;
        data_pad  = '0;
        data_raw  = '0;
        unique case (state)
            FIRST: src_rdy = !hdr_val || bus.dst_eth_hdr_hdr_rdy;
            MID: begin
                data_val = bus.src_eth_hdr_val;
                src_rdy  = bus.dst_eth_hdr_data_rdy;
                data_raw = {rem_reg, bus.src_eth_hdr_data[DATA_W-1 -: HDR_W]};
                if (bus.src_eth_hdr_data_last && fold_in) begin
                    data_last = 1'b1;
                    data_pad  = frame_pad;
                end
            end
            DRAIN: begin
                data_val  = 1'b1;
                data_last = 1'b1;
                data_pad  = drain_pad;
                data_raw  = {rem_reg, {HDR_W{1'b0}}};
            end
            default: ;
        endcase
    end

`ifdef ETH_RX_HDR_ZERO_PAD_EN
    always_comb begin
        data_out = data_raw;
        if (data_last) begin
            for (int i = 0; i < DATA_BYTES; i++) begin
                if (i >= DATA_BYTES - int'(data_pad)) data_out[DATA_W-1-8*i -: 8] = 8'h00;
            end
        end
    end
`else
    assign data_out = data_raw;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= FIRST;
            hdr_val     <= 1'b0;
            dst_mac     <= '0;
            src_mac     <= '0;
            eth_type    <= '0;
            payload_len <= '0;
            rem_reg     <= '0;
            drain_pad   <= '0;
        end else begin
            if (hdr_fire) hdr_val <= 1'b0;
            unique case (state)
                FIRST: begin
                    if (in_fire) begin
                        rem_reg <= bus.src_eth_hdr_data[REM_W-1:0];
                        if (!runt) begin
                            hdr_val     <= 1'b1;
                            dst_mac     <= bus.src_eth_hdr_data[DATA_W-1 -: 48];
                            src_mac     <= bus.src_eth_hdr_data[DATA_W-49 -: 48];
                            eth_type    <= bus.src_eth_hdr_data[DATA_W-97 -: 16];
                            payload_len <= bus.src_eth_hdr_frame_size - MTU_SIZE_W'(HDR_BYTES);
                            if (bus.src_eth_hdr_data_last) begin
                                state     <= DRAIN;
                                drain_pad <= frame_pad;
                            end else begin
                                state <= MID;
                            end
                        end
                    end
                end
                MID: begin
                    if (in_fire) begin
                        rem_reg <= bus.src_eth_hdr_data[REM_W-1:0];
                        if (bus.src_eth_hdr_data_last) begin
                            if (fold_in) begin
                                state <= FIRST;
                            end else begin
                                state     <= DRAIN;
                                drain_pad <= frame_pad;
                            end
                        end
                    end
                end
                DRAIN: if (bus.dst_eth_hdr_data_rdy) state <= FIRST;
                default: state <= FIRST;
            endcase
        end
    end

    assign bus.eth_hdr_src_rdy           = src_rdy;
    assign bus.eth_hdr_dst_hdr_val       = hdr_val;
    assign bus.eth_hdr_dst_dst_mac       = dst_mac;
    assign bus.eth_hdr_dst_src_mac       = src_mac;
    assign bus.eth_hdr_dst_eth_type      = eth_type;
    assign bus.eth_hdr_dst_payload_len   = payload_len;
    assign bus.eth_hdr_dst_data_val      = data_val;
    assign bus.eth_hdr_dst_data          = data_out;
    assign bus.eth_hdr_dst_data_last     = data_last;
    assign bus.eth_hdr_dst_data_padbytes = data_pad;
    assign bus.dbg_state                 = state;
endmodule

// File: tb/tb_eth_rx_hdr_parse.sv
// Directed bench for eth_rx_hdr_parse: header/payload extraction, stalls, runts and mid-frame reset.
module tb_eth_rx_hdr_parse;
    localparam int DW = 512;
    localparam int PW = 6;
    localparam int MW = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    eth_rx_hdr_parse_if #(.DATA_W(DW), .PADBYTES_W(PW), .MTU_SIZE_W(MW)) bus ();

    eth_rx_hdr_parse #(.DATA_W(DW), .DATA_BYTES(DW / 8), .PADBYTES_W(PW), .MTU_SIZE_W(MW)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int tests_run    = 0;
    int tests_failed = 0;
    bit rand_mode    = 1'b0;

    logic [127:0]  exp_hdr_q[$];
    logic [DW-1:0] exp_data_q[$];
    logic [63:0]   exp_mask_q[$];
    logic [6:0]    exp_meta_q[$];
    logic [127:0]  got_hdr_q[$];
    logic [DW-1:0] got_data_q[$];
    logic [6:0]    got_meta_q[$];

    // Capture completed transfers half a cycle before the edge that commits them.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (bus.eth_hdr_dst_hdr_val && bus.dst_eth_hdr_hdr_rdy)
                got_hdr_q.push_back({bus.eth_hdr_dst_dst_mac, bus.eth_hdr_dst_src_mac,
                                     bus.eth_hdr_dst_eth_type, bus.eth_hdr_dst_payload_len});
            if (bus.eth_hdr_dst_data_val && bus.dst_eth_hdr_data_rdy) begin
                got_data_q.push_back(bus.eth_hdr_dst_data);
                got_meta_q.push_back({bus.eth_hdr_dst_data_last, bus.eth_hdr_dst_data_padbytes});
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish expected finish before 500us");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] fb(input int seed, input int k);
        return 8'((seed + k) % 256);
    endfunction

    function automatic logic [DW-1:0] beat_data(input int f, input int seed, input int b);
        logic [DW-1:0] d;
        for (int j = 0; j < 64; j++) begin
            if (64 * b + j < f) d[DW-1-8*j -: 8] = fb(seed, 64 * b + j);
            else                d[DW-1-8*j -: 8] = 8'($urandom_range(0, 255));
        end
        return d;
    endfunction

    function automatic logic [DW-1:0] expand(input logic [63:0] m);
        logic [DW-1:0] r;
        for (int j = 0; j < 64; j++) r[DW-1-8*j -: 8] = {8{m[63-j]}};
        return r;
    endfunction

    // Advance to just after the next rising edge; all inputs change only here.
    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_mode) begin
            bus.dst_eth_hdr_data_rdy = 1'($urandom_range(0, 1));
            bus.dst_eth_hdr_hdr_rdy  = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic push_expect(input int f, input int seed);
        logic [127:0]  h;
        logic [DW-1:0] d;
        logic [63:0]   m;
        int p, nb, idx, pad;
        if (f <= 14) return;
        p = f - 14;
        for (int k = 0; k < 14; k++) h[127-8*k -: 8] = fb(seed, k);
        h[15:0] = 16'(p);
        exp_hdr_q.push_back(h);
        nb = (p + 63) / 64;
        for (int b = 0; b < nb; b++) begin
            d = '0;
            m = '0;
            for (int j = 0; j < 64; j++) begin
                idx = 14 + 64 * b + j;
                if (idx < f) begin
                    d[DW-1-8*j -: 8] = fb(seed, idx);
                    m[63-j] = 1'b1;
                end
`ifdef ETH_RX_HDR_ZERO_PAD_EN
                else m[63-j] = 1'b1;
`endif
            end
            pad = (b == nb - 1) ? (((p % 64) == 0) ? 0 : 64 - (p % 64)) : 0;
            exp_data_q.push_back(d);
            exp_mask_q.push_back(m);
            exp_meta_q.push_back({(b == nb - 1) ? 1'b1 : 1'b0, 6'(pad)});
        end
    endtask

    task automatic drive_beat(input logic [DW-1:0] d, input int f, input bit last,
                              input bit chk_val, output int waited);
        bus.src_eth_hdr_val           = 1'b1;
        bus.src_eth_hdr_data          = d;
        bus.src_eth_hdr_frame_size    = MW'(f);
        bus.src_eth_hdr_data_last     = last;
        bus.src_eth_hdr_data_padbytes = PW'($urandom_range(0, 63));
        waited = 0;
        @(negedge clk);
        if (chk_val) check("beat1_same_cycle_val", bus.eth_hdr_dst_data_val, 1'b1);
        while (!bus.eth_hdr_src_rdy && waited < 200) begin
            tick();
            @(negedge clk);
            waited++;
        end
        if (waited >= 200) begin
            tests_run++;
            tests_failed++;
            $error("FAIL src_rdy_timeout: observed no ready expected ready within 200 cycles");
        end
        tick();
        bus.src_eth_hdr_val = 1'b0;
    endtask

    task automatic send_frame(input int f, input int seed, input bit chk_lat);
        int nb, w;
        push_expect(f, seed);
        nb = (f + 63) / 64;
        for (int b = 0; b < nb; b++)
            drive_beat(beat_data(f, seed, b), f, (b == nb - 1), chk_lat && (b == 1), w);
    endtask

    task automatic wait_out();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            #1;
            if (got_hdr_q.size() == exp_hdr_q.size() && got_data_q.size() == exp_data_q.size()) break;
            tick();
        end
        tick();
    endtask

    task automatic check_all(input string tag);
        logic [DW-1:0] g, e, bm;
        check({tag, "_hdr_count"}, got_hdr_q.size(), exp_hdr_q.size());
        check({tag, "_data_count"}, got_data_q.size(), exp_data_q.size());
        while (got_hdr_q.size() > 0 && exp_hdr_q.size() > 0)
            check({tag, "_hdr"}, got_hdr_q.pop_front(), exp_hdr_q.pop_front());
        while (got_data_q.size() > 0 && exp_data_q.size() > 0) begin
            g  = got_data_q.pop_front();
            e  = exp_data_q.pop_front();
            bm = expand(exp_mask_q.pop_front());
            check({tag, "_data"}, g & bm, e & bm);
            check({tag, "_meta"}, got_meta_q.pop_front(), exp_meta_q.pop_front());
        end
        got_hdr_q.delete(); got_data_q.delete(); got_meta_q.delete();
        exp_hdr_q.delete(); exp_data_q.delete(); exp_mask_q.delete(); exp_meta_q.delete();
    endtask

    initial begin
        int  w;
        bit  ok;
        bus.src_eth_hdr_val           = 1'b0;
        bus.src_eth_hdr_data          = '0;
        bus.src_eth_hdr_frame_size    = '0;
        bus.src_eth_hdr_data_last     = 1'b0;
        bus.src_eth_hdr_data_padbytes = '0;
        bus.dst_eth_hdr_hdr_rdy       = 1'b1;
        bus.dst_eth_hdr_data_rdy      = 1'b1;

        // Reset state
        repeat (3) tick();
        @(negedge clk);
        check("rst_state", bus.dbg_state, 2'd0);
        check("rst_hdr_val", bus.eth_hdr_dst_hdr_val, 1'b0);
        check("rst_data_val", bus.eth_hdr_dst_data_val, 1'b0);
        check("rst_src_rdy", bus.eth_hdr_src_rdy, 1'b1);
        check("rst_dst_mac", bus.eth_hdr_dst_dst_mac, 48'h0);
        check("rst_payload_len", bus.eth_hdr_dst_payload_len, 16'h0);
        tick();
        rst = 1'b1;
        tick();

        // F=64, byte i = i: single beat, emitted from DRAIN one cycle after beat 0
        send_frame(64, 0, 1'b0);
        @(negedge clk);
        check("f64_drain_val", bus.eth_hdr_dst_data_val, 1'b1);
        check("f64_drain_state", bus.dbg_state, 2'd2);
        check("f64_drain_src_rdy", bus.eth_hdr_src_rdy, 1'b0);
        tick();
        wait_out();
        check("f64_hdr_const", got_hdr_q[0], 128'h000102030405_060708090A0B_0C0D_0032);
        check("f64_meta_const", got_meta_q[0], 7'h4E);
        check_all("f64");

        // F=128: first payload beat valid while input beat 1 is presented, then DRAIN
        send_frame(128, 3, 1'b1);
        wait_out();
        check("f128_meta0", got_meta_q[0], 7'h00);
        check("f128_meta1", got_meta_q[1], 7'h4E);
        check_all("f128");

        // F=70: two input beats fold into one payload beat, padbytes 8
        send_frame(70, 17, 1'b1);
        @(negedge clk);
        check("f70_back_to_first", bus.dbg_state, 2'd0);
        tick();
        wait_out();
        check("f70_meta", got_meta_q[0], 7'h48);
        check_all("f70");

        // F=78: 14-byte tail exactly fills the free lanes, padbytes 0
        send_frame(78, 200, 1'b1);
        @(negedge clk);
        check("f78_no_drain", bus.dbg_state, 2'd0);
        tick();
        wait_out();
        check("f78_meta", got_meta_q[0], 7'h40);
        check_all("f78");

        // Runt F=10: consumed in one cycle, nothing emitted
        drive_beat(beat_data(10, 85, 0), 10, 1'b1, 1'b0, w);
        check("runt_accept_wait", w, 0);
        ok = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bus.eth_hdr_dst_hdr_val !== 1'b0 || bus.eth_hdr_dst_data_val !== 1'b0) ok = 1'b0;
            tick();
        end
        check("runt_quiet", ok, 1'b1);
        check_all("runt");

        // Header stall: frame 2 beat 0 held off until frame 1 header is taken
        bus.dst_eth_hdr_hdr_rdy = 1'b0;
        send_frame(64, 64, 1'b0);
        tick();
        tick();
        bus.src_eth_hdr_val        = 1'b1;
        bus.src_eth_hdr_data       = beat_data(64, 128, 0);
        bus.src_eth_hdr_frame_size = 16'd64;
        bus.src_eth_hdr_data_last  = 1'b1;
        ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.eth_hdr_src_rdy !== 1'b0) ok = 1'b0;
            tick();
        end
        check("stall_src_rdy_low", ok, 1'b1);
        @(negedge clk);
        check("stall_hdr_held", bus.eth_hdr_dst_hdr_val, 1'b1);
        tick();
        bus.dst_eth_hdr_hdr_rdy = 1'b1;
        send_frame(64, 128, 1'b0);
        wait_out();
        check_all("stall");

        // 100 random-length frames with random header/payload back-pressure
        rand_mode = 1'b1;
        for (int n = 0; n < 100; n++) begin
            send_frame($urandom_range(1, 200), $urandom_range(0, 255), 1'b0);
            if ($urandom_range(0, 3) == 0) tick();
        end
        rand_mode = 1'b0;
        bus.dst_eth_hdr_hdr_rdy  = 1'b1;
        bus.dst_eth_hdr_data_rdy = 1'b1;
        wait_out();
        check_all("rand");

        // Reset while in MID of a 3-beat frame, then a clean F=64 frame
        bus.dst_eth_hdr_hdr_rdy  = 1'b0;
        bus.dst_eth_hdr_data_rdy = 1'b0;
        drive_beat(beat_data(150, 32, 0), 150, 1'b0, 1'b0, w);
        @(negedge clk);
        check("midrst_in_mid", bus.dbg_state, 2'd1);
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        @(negedge clk);
        check("midrst_hdr_val", bus.eth_hdr_dst_hdr_val, 1'b0);
        check("midrst_data_val", bus.eth_hdr_dst_data_val, 1'b0);
        check("midrst_state", bus.dbg_state, 2'd0);
        tick();
        bus.dst_eth_hdr_hdr_rdy  = 1'b1;
        bus.dst_eth_hdr_data_rdy = 1'b1;
        send_frame(64, 0, 1'b0);
        wait_out();
        check("midrst_hdr_const", got_hdr_q[0], 128'h000102030405_060708090A0B_0C0D_0032);
        check_all("midrst");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
